ext_arbiter: RTL and testbench
==============================

# ext_arbiter

Shares one immediate-extension unit between two requesters: requester 0 is the decode-stage ALU-immediate path and requester 1 is the branch-offset path. Requests use valid/ready handshakes and are arbitrated, by default round-robin. The winner's immediate and extension op are latched, extended in a dedicated cycle, and returned through a single registered response port tagged with the requester ID.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_imm  in  16  requester 0 immediate
- req0_eop  in  2  requester 0 extension op
- req0_ready  out  1  requester 0 request accepted this cycle
- req1_valid, req1_imm, req1_eop, req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  response holds a valid result
- rsp_id  out  1  requester that owns the response
- rsp_data  out  32  extended result
- rsp_ready  in  1  consumer takes the response this cycle
- busy  out  1  high when the FSM is not IDLE

## Operation
- **EOp encoding**, result = f(imm):
  - 00: sign-extend, {{16{imm[15]}},imm}
  - 01: zero-extend, {16'b0,imm}
  - 10: load-upper, {imm,16'b0}
  - 11: sign-extend then shift left 2, truncated to 32 bits
- **FSM states:** IDLE, EXT, RESP.
  - IDLE: accept the winning request if any, then go to EXT. With no request, stay in IDLE.
  - EXT: compute f(latched imm, latched eop) into rsp_data and set rsp_valid. Always go to RESP after exactly 1 cycle.
  - RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready. When rsp_ready=1 and a request is valid, accept it the same cycle and go to EXT (back-to-back). When rsp_ready=1 and no request is valid, clear rsp_valid and go to IDLE.
- **Accept window:** state==IDLE, or state==RESP && rsp_ready.
- **reqN_ready** is combinational. It is 1 only for the winner, and only inside the accept window. It is never 1 for both requesters at once.
- **Handshake:** a transfer occurs when reqN_valid && reqN_ready. At that edge, imm, eop and ID are latched. After the transfer, the requester may change or drop its inputs freely.
- **Arbitration:**
  - Exactly one requester valid: it wins.
  - Both valid: the priority pointer decides. The pointer resets to 0 and becomes 1-N after a grant to N.
- **Valid stability:** a request not yet accepted is not required to hold valid. Dropping valid withdraws the request with no side effects.
- **rsp_id** equals the ID of the requester accepted in the matching handshake.

## Timing
- **Reset values:**
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=32'h0, priority pointer=0, busy=0.
  - reqN_ready=0 while reset is high.
- **Latency:** handshake at edge T, then rsp_valid=1 and data valid from after edge T+1.
- **Throughput:** one result per 2 cycles when rsp_ready is held high.
- **Response backpressure:** rsp_ready low stalls in RESP indefinitely. Outputs do not change and no request is accepted.
- **Simultaneous rsp_ready and request in RESP:** the old response retires and the new request is latched at the same edge. rsp_valid drops to 0 for the EXT cycle, then rises again.
- **Reset mid-operation:** reset dominates all other inputs at the edge. The in-flight request is discarded, no response is issued, and the pointer returns to 0.
- **Pointer update:** only on an accepted handshake, never on a withdrawn request.

## Configuration
- **ARB_RR_EN defined:** round-robin arbitration as above.
- **ARB_RR_EN undefined:** fixed priority, requester 0 always wins when both are valid. The priority pointer is not implemented. All other behaviour is identical.

## Test plan
- Reset, then req0 with imm=16'h8001, eop=00 at cycle T. Required: req0_ready=1 at T; at T+2, rsp_valid=1, rsp_id=0, rsp_data=32'hFFFF8001.
- Single requests, one per case. Required results:
  - imm=16'h8001, eop=01: 32'h00008001
  - imm=16'h1234, eop=10: 32'h12340000
  - imm=16'hFFFF, eop=11: 32'hFFFFFFFC
  - imm=16'h4000, eop=11: 32'h00010000
- Both requesters continuously valid with rsp_ready=1. Required with ARB_RR_EN: rsp_id sequence 0,1,0,1. Required without it: 0,0,0,0.
- Hold rsp_ready=0 for 5 cycles in RESP while req1 stays valid. Required: rsp_data stable, req1_ready=0 throughout; when rsp_ready rises, req1 is accepted in that same cycle.
- Assert reset in EXT after an accepted request. Required: the next cycle shows rsp_valid=0 and busy=0, and no response for the discarded request ever appears.
- Raise req1_valid for one cycle while in RESP with rsp_ready=0, then drop it. Required: no grant, no response with rsp_id=1, pointer unchanged.

Source files
------------

// File: rtl/ext_arbiter.sv
// ext_arbiter: shares one immediate-extension unit between the decode-stage
// ALU-immediate path (requester 0) and the branch-offset path (requester 1).
// One request is accepted, extended in a dedicated cycle, then presented on a
// registered response port tagged with the requester ID.
//
// Build option: ARB_RR_EN selects round-robin arbitration when both requesters
// are valid. Without it requester 0 always wins and no priority pointer exists.
//
// state  | meaning
// S_IDLE | no work held; accept the winning request if any
// S_EXT  | latched request is being extended; response not yet valid
// S_RESP | response held stable until rsp_ready; may accept back-to-back
module ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_eop,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_eop,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  input  logic        rsp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  eop_q, eop_d;
  logic        id_q, id_d;
`ifdef ARB_RR_EN
  logic        prio_q, prio_d;
`endif

  logic win_open;
  logic win_id;
  logic grant0;
  logic grant1;
  logic accept;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] res;
    case (eop)
      2'b00:   res = {{16{imm[15]}}, imm};
      2'b01:   res = {16'h0000, imm};
      2'b10:   res = {imm, 16'h0000};
      default: res = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return res;
  endfunction

  // Arbitration and combinational ready generation inside the accept window
  always_comb begin
    win_open = !reset && ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    if (req0_valid && req1_valid) begin
`ifdef ARB_RR_EN
      win_id = prio_q;
`else
      win_id = 1'b0;
`endif
    end else begin
      win_id = req1_valid;
    end
    grant0 = win_open && req0_valid && !win_id;
    grant1 = win_open && req1_valid && win_id;
    accept = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state, request latch and response computation
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    imm_d       = imm_q;
    eop_d       = eop_q;
    id_d        = id_q;
`ifdef ARB_RR_EN
    prio_d      = prio_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_EXT;
        end
      end
      S_EXT: begin
        rsp_data_d  = ext_imm(imm_q, eop_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? S_EXT : S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    // The latch is shared by both entry points into S_EXT
    if (accept) begin
      imm_d = win_id ? req1_imm : req0_imm;
      eop_d = win_id ? req1_eop : req0_eop;
      id_d  = win_id;
`ifdef ARB_RR_EN
      prio_d = !win_id;
`endif
    end
  end

  // State and output registers; reset discards any in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 32'h0;
      imm_q       <= 16'h0;
      eop_q       <= 2'b00;
      id_q        <= 1'b0;
`ifdef ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      imm_q       <= imm_d;
      eop_q       <= eop_d;
      id_q        <= id_d;
`ifdef ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_imm = 16'h0;
  logic [1:0]  req0_eop = 2'b00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_imm = 16'h0;
  logic [1:0]  req1_eop = 2'b00;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ext_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_imm(req0_imm), .req0_eop(req0_eop), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_imm(req1_imm), .req1_eop(req1_eop), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension, written as plain integer arithmetic
  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] eop);
    int s;
    int u;
    s = int'($signed(imm));
    u = int'(imm);
    case (eop)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // Model: one in-flight slot, one response register and a priority pointer
  logic        m_inflight = 1'b0;
  logic [15:0] m_imm = 16'h0;
  logic [1:0]  m_eop = 2'b00;
  logic        m_id = 1'b0;
  logic        m_rsp_valid = 1'b0;
  logic        m_rsp_id = 1'b0;
  logic [31:0] m_rsp_data = 32'h0;
  logic        m_ptr = 1'b0;

  function automatic logic m_open();
    return !reset && !m_inflight && (!m_rsp_valid || rsp_ready);
  endfunction

  function automatic logic m_pick();
    if (req0_valid && req1_valid) begin
`ifdef ARB_RR_EN
      return m_ptr;
`else
      return 1'b0;
`endif
    end
    return req1_valid;
  endfunction

  // Model advance on each rising edge using the pre-edge inputs
  always @(posedge clk) begin : model_step
    logic take;
    logic w;
    take = m_open() && (req0_valid || req1_valid);
    w    = m_pick();
    if (reset) begin
      m_inflight  = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_id    = 1'b0;
      m_rsp_data  = 32'h0;
      m_ptr       = 1'b0;
    end else begin
      if (m_inflight) begin
        m_rsp_valid = 1'b1;
        m_rsp_id    = m_id;
        m_rsp_data  = ext_ref(m_imm, m_eop);
        m_inflight  = 1'b0;
      end else if (m_rsp_valid && rsp_ready) begin
        m_rsp_valid = 1'b0;
      end
      if (take) begin
        m_inflight = 1'b1;
        m_id       = w;
        m_imm      = w ? req1_imm : req0_imm;
        m_eop      = w ? req1_eop : req0_eop;
        m_ptr      = !w;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin : compare
    logic open;
    logic w;
    open = m_open();
    w    = m_pick();
    check("req0_ready", 32'(req0_ready), 32'(open && req0_valid && !w));
    check("req1_ready", 32'(req1_ready), 32'(open && req1_valid && w));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    check("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
    check("rsp_data", rsp_data, m_rsp_data);
    check("busy", 32'(busy), 32'(m_inflight || m_rsp_valid));
    check("ready_onehot", 32'(req0_ready && req1_ready), 32'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One isolated request from requester id, response checked two cycles later
  task automatic single(input logic id, input logic [15:0] imm, input logic [1:0] eop,
                        input logic [31:0] exp, input string name);
    if (id) begin
      req1_valid = 1'b1; req1_imm = imm; req1_eop = eop;
    end else begin
      req0_valid = 1'b1; req0_imm = imm; req0_eop = eop;
    end
    @(negedge clk);
    check({name, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'(1));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check({name, "_valid"}, 32'(rsp_valid), 32'(1));
    check({name, "_id"}, 32'(rsp_id), 32'(id));
    check({name, "_data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin : stim
    int got;
    logic [0:3] seq;
    logic [0:3] seq_exp;
    logic both_win;

    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy", 32'(busy), 32'(0));
    step();

    single(1'b0, 16'h8001, 2'b00, 32'hFFFF8001, "sext");
    single(1'b0, 16'h8001, 2'b01, 32'h00008001, "zext");
    single(1'b1, 16'h1234, 2'b10, 32'h12340000, "lui");
    single(1'b0, 16'hFFFF, 2'b11, 32'hFFFFFFFC, "shl_neg");
    single(1'b1, 16'h4000, 2'b11, 32'h00010000, "shl_pos");

    // Both requesters continuously valid with rsp_ready held high
    pulse_reset();
    req0_valid = 1'b1; req0_imm = 16'h0011; req0_eop = 2'b01;
    req1_valid = 1'b1; req1_imm = 16'h0022; req1_eop = 2'b01;
    rsp_ready  = 1'b1;
    got = 0;
    seq = 4'b0000;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        seq[got] = rsp_id;
        got++;
      end
      step();
    end
    check("seq_count", 32'(got), 32'(4));
`ifdef ARB_RR_EN
    seq_exp = 4'b0101;
`else
    seq_exp = 4'b0000;
`endif
    check("seq_ids", 32'(seq), 32'(seq_exp));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    step();
    rsp_ready = 1'b0;

    // Backpressure: response held while req1 waits
    req0_valid = 1'b1; req0_imm = 16'h1234; req0_eop = 2'b10;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_imm = 16'h00FF; req1_eop = 2'b01;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_req1_ready", 32'(req1_ready), 32'(0));
      check("bp_rsp_data", rsp_data, 32'h12340000);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req1_ready), 32'(1));
    step();
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    step();
    @(negedge clk);
    check("bp_next_id", 32'(rsp_id), 32'(1));
    check("bp_next_data", rsp_data, 32'h000000FF);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Reset while the accepted request is in EXT
    req0_valid = 1'b1; req0_imm = 16'hAAAA; req0_eop = 2'b00;
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ext_valid", 32'(rsp_valid), 32'(0));
    check("rst_ext_busy", 32'(busy), 32'(0));
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      @(negedge clk);
      check("rst_ext_no_rsp", 32'(rsp_valid), 32'(0));
    end
    step();
    rsp_ready = 1'b0;

    // Withdrawn request in RESP must not move the pointer
    pulse_reset();
    req0_valid = 1'b1; req0_imm = 16'h0005; req0_eop = 2'b00;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_imm = 16'h0007; req1_eop = 2'b00;
    @(negedge clk);
    check("wd_req1_ready", 32'(req1_ready), 32'(0));
    step();
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("wd_rsp_id", 32'(rsp_id), 32'(0));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_imm = 16'h0001; req0_eop = 2'b01;
    req1_valid = 1'b1; req1_imm = 16'h0002; req1_eop = 2'b01;
`ifdef ARB_RR_EN
    both_win = 1'b1;
`else
    both_win = 1'b0;
`endif
    @(negedge clk);
    check("wd_winner", 32'(req1_ready), 32'(both_win));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    @(negedge clk);
    check("wd_after_id", 32'(rsp_id), 32'(both_win));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 149) == 0);
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_imm   = 16'($urandom);
      req1_imm   = 16'($urandom);
      req0_eop   = 2'($urandom);
      req1_eop   = 2'($urandom);
      rsp_ready  = ($urandom_range(0, 9) < 6);
      step();
    end
    reset      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
